adc_sample_filter: RTL and testbench

ADC_SAMPLE_FILTER -- requirements
Module: adc_sample_filter

---
 rtl/adc_pkg.sv | 30 +++
 rtl/adc_ch_accum.sv | 41 ++++
 rtl/adc_sample_filter.sv | 147 ++++++++++++++
 tb/tb_adc_sample_filter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared constants, channel map and FSM encoding for the ADC sample filter.
package adc_pkg;

  localparam int DATA_W    = 12;
  localparam int NUM_CH    = 5;
  localparam int MAX_SHIFT = 4;
  localparam int CH_ID_W   = 5;
  localparam int SHIFT_W   = 3;
  localparam int CNT_W     = 5;

  // Output index 0 sits in the LSBs: index0=3, index1=6, index2=1, index3=2, index4=4.
  localparam logic [NUM_CH*CH_ID_W-1:0] CH_MAP = {5'd4, 5'd2, 5'd1, 5'd6, 5'd3};

  typedef enum logic [0:0] {
    ACCUM  = 1'b0,
    FINISH = 1'b1
  } state_e;

  function automatic logic [SHIFT_W-1:0] clamp_shift(input logic [SHIFT_W-1:0] req,
                                                     input int max_s);
    logic [SHIFT_W-1:0] lim;
    lim = SHIFT_W'(max_s);
    if (req > lim) begin
      return lim;
    end else begin
      return req;
    end
  endfunction

endpackage

// File: rtl/adc_ch_accum.sv
// Per-channel sample accumulator with saturating beat count; a clear can
// coincide with a new beat, which then seeds the next epoch.
module adc_ch_accum #(
  parameter int DATA_W = adc_pkg::DATA_W,
  parameter int ACC_W  = adc_pkg::DATA_W + adc_pkg::MAX_SHIFT,
  parameter int CNT_W  = adc_pkg::CNT_W
) (
  input  logic              clk_core,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_add,
  input  logic [DATA_W-1:0] i_data,
  output logic [ACC_W-1:0]  o_acc,
  output logic [CNT_W-1:0]  o_cnt
);
  import adc_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [ACC_W-1:0] w_data_ext;

  assign w_data_ext = {{(ACC_W-DATA_W){1'b0}}, i_data};

  // Accumulate / clear / reload
  always_ff @(posedge clk_core) begin
    if (reset) begin
      o_acc <= '0;
      o_cnt <= '0;
    end else if (i_clear) begin
      o_acc <= i_add ? w_data_ext : '0;
      o_cnt <= i_add ? CNT_ONE : '0;
    end else if (i_add) begin
      o_acc <= o_acc + w_data_ext;
      if (o_cnt != CNT_MAX) begin
        o_cnt <= o_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/adc_sample_filter.sv
// Averages mapped ADC sequencer channels over 2^shift packets and publishes
// all channel results together once the register bank is not on hold.
module adc_sample_filter #(
  parameter int NUM_CH    = adc_pkg::NUM_CH,
  parameter int DATA_W    = adc_pkg::DATA_W,
  parameter int MAX_SHIFT = adc_pkg::MAX_SHIFT,
  parameter logic [NUM_CH*5-1:0] CH_MAP = adc_pkg::CH_MAP
) (
  input  logic                     clk_core,
  input  logic                     reset,
  input  logic                     adc_response_valid,
  input  logic [4:0]               adc_response_channel,
  input  logic [DATA_W-1:0]        adc_response_data,
  input  logic                     adc_response_endofpacket,
  input  logic [2:0]               avg_shift,
  input  logic                     hold,
  output logic [NUM_CH*DATA_W-1:0] ch_avg,
  output logic [NUM_CH-1:0]        ch_complete,
  output logic                     samples_ready,
  output logic                     overrun
);
  import adc_pkg::*;

  localparam int ACC_W = DATA_W + MAX_SHIFT;
  localparam int PKT_W = (MAX_SHIFT > 0) ? MAX_SHIFT : 1;
  localparam logic [PKT_W:0]   PKT_ONE = (PKT_W+1)'(1'b1);
  localparam logic [PKT_W-1:0] PKT_INC = PKT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  state_e                     r_state;
  logic [SHIFT_W-1:0]         r_shift_l;
  logic [PKT_W-1:0]           r_pkt_cnt;
  logic [NUM_CH*DATA_W-1:0]   r_pend_avg;
  logic [NUM_CH-1:0]          r_pend_mask;
  logic                       r_pend_flag;

  logic [SHIFT_W-1:0]         w_shift_req;
  logic [SHIFT_W-1:0]         w_shift_eff;
  logic [PKT_W:0]             w_pkt_last;
  logic [CNT_W-1:0]           w_cnt_target;
  logic                       w_eop;
  logic                       w_epoch_end;
  logic                       w_finish;
  logic [NUM_CH-1:0]          w_hit;
  logic [ACC_W-1:0]           w_acc [NUM_CH];
  logic [CNT_W-1:0]           w_cnt [NUM_CH];
  logic [NUM_CH*DATA_W-1:0]   w_new_avg;
  logic [NUM_CH-1:0]          w_new_mask;

  assign w_eop       = adc_response_valid && adc_response_endofpacket;
  assign w_finish    = (r_state == FINISH);
  assign w_epoch_end = w_eop && ({1'b0, r_pkt_cnt} == w_pkt_last);

  // An eop seen during FINISH already belongs to the next epoch, so it is
  // judged against the shift being latched on that same edge.
  always_comb begin
    w_shift_req = clamp_shift(avg_shift, MAX_SHIFT);
    if (w_finish) begin
      w_shift_eff = w_shift_req;
    end else begin
      w_shift_eff = r_shift_l;
    end
    w_pkt_last   = (PKT_ONE << w_shift_eff) - PKT_ONE;
    w_cnt_target = CNT_ONE << r_shift_l;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign w_hit[i] = adc_response_valid &&
                      (adc_response_channel == CH_MAP[i*CH_ID_W +: CH_ID_W]);

    adc_ch_accum #(
      .DATA_W(DATA_W),
      .ACC_W (ACC_W),
      .CNT_W (CNT_W)
    ) u_accum (
      .clk_core(clk_core),
      .reset   (reset),
      .i_clear (w_finish),
      .i_add   (w_hit[i]),
      .i_data  (adc_response_data),
      .o_acc   (w_acc[i]),
      .o_cnt   (w_cnt[i])
    );

    assign w_new_avg[i*DATA_W +: DATA_W] = w_acc[i][r_shift_l +: DATA_W];
    assign w_new_mask[i]                 = (w_cnt[i] == w_cnt_target);
  end

  // Epoch FSM: packet counting, one-cycle FINISH, shift latching
  always_ff @(posedge clk_core) begin
    if (reset) begin
      r_state   <= ACCUM;
      r_pkt_cnt <= '0;
      r_shift_l <= w_shift_req;
    end else begin
      if (w_eop) begin
        if (w_epoch_end) begin
          r_pkt_cnt <= '0;
        end else begin
          r_pkt_cnt <= r_pkt_cnt + PKT_INC;
        end
      end
      case (r_state)
        ACCUM: begin
          r_state <= w_epoch_end ? FINISH : ACCUM;
        end
        FINISH: begin
          r_shift_l <= w_shift_req;
          r_state   <= w_epoch_end ? FINISH : ACCUM;
        end
        default: begin
          r_state <= ACCUM;
        end
      endcase
    end
  end

  // Pending capture in FINISH and atomic publish when hold is low
  always_ff @(posedge clk_core) begin
    if (reset) begin
      r_pend_avg    <= '0;
      r_pend_mask   <= '0;
      r_pend_flag   <= 1'b0;
      ch_avg        <= '0;
      ch_complete   <= '0;
      samples_ready <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      samples_ready <= 1'b0;
      if (r_pend_flag && !hold) begin
        ch_avg        <= r_pend_avg;
        ch_complete   <= r_pend_mask;
        samples_ready <= 1'b1;
        r_pend_flag   <= 1'b0;
      end
      if (w_finish) begin
        r_pend_avg  <= w_new_avg;
        r_pend_mask <= w_new_mask;
        r_pend_flag <= 1'b1;
        if (r_pend_flag && hold) begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_sample_filter.sv
// Self-checking bench: table vectors, directed corner sequences and a
// randomized run scored against a packet-level averaging model.
module tb_adc_sample_filter;

  logic        clk_core = 1'b0;
  logic        reset;
  logic        valid;
  logic [4:0]  chan;
  logic [11:0] data;
  logic        eop;
  logic [2:0]  avg_shift;
  logic        hold;
  logic [59:0] ch_avg;
  logic [4:0]  ch_complete;
  logic        samples_ready;
  logic        overrun;

  always #5 clk_core = ~clk_core;

  adc_sample_filter dut (
    .clk_core                (clk_core),
    .reset                   (reset),
    .adc_response_valid      (valid),
    .adc_response_channel    (chan),
    .adc_response_data       (data),
    .adc_response_endofpacket(eop),
    .avg_shift               (avg_shift),
    .hold                    (hold),
    .ch_avg                  (ch_avg),
    .ch_complete             (ch_complete),
    .samples_ready           (samples_ready),
    .overrun                 (overrun)
  );

  typedef struct packed {
    logic [4:0]  present;
    logic [59:0] d;
    logic [59:0] exp_avg;
    logic [4:0]  exp_cpl;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;
  int pulse_cnt = 0;
  logic [59:0] got_avg_q[$];
  logic [4:0]  got_cpl_q[$];
  logic [59:0] exp_avg_q[$];
  logic [4:0]  exp_cpl_q[$];
  int map_id [5] = '{3, 6, 1, 2, 4};
  int unm_id [5] = '{0, 5, 7, 9, 31};
  int m_sum [5];
  int m_cnt [5];
  int m_pk;
  int m_shift;
  vec_t tbl [4];

  always @(negedge clk_core) begin
    if (samples_ready === 1'b1) begin
      pulse_cnt++;
      got_avg_q.push_back(ch_avg);
      got_cpl_q.push_back(ch_complete);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_beat(input logic [4:0] c, input logic [11:0] d, input logic e);
    @(negedge clk_core);
    valid = 1'b1; chan = c; data = d; eop = e;
    @(posedge clk_core);
    #1;
    valid = 1'b0; eop = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_core);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_core);
    reset = 1'b1; valid = 1'b0; eop = 1'b0;
    @(negedge clk_core);
    reset = 1'b0;
    #1;
  endtask

  task automatic set_shift(input logic [2:0] s);
    avg_shift = s;
    do_reset();
  endtask

  task automatic send_pkt(input logic [4:0] pres, input logic [59:0] d);
    int last = -1;
    for (int i = 0; i < 5; i++) if (pres[i]) last = i;
    send_beat(5'd0, 12'hFFF, 1'b0);
    if (last < 0) send_beat(5'd0, 12'h7FF, 1'b1);
    for (int i = 0; i < 5; i++)
      if (pres[i]) send_beat(5'(map_id[i]), d[i*12 +: 12], (i == last));
  endtask

  task automatic wait_pub(input int start, input string name, output int lat);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_core);
      #1;
      if (pulse_cnt > start) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: no samples_ready within 40 cycles", name);
    end
  endtask

  // Packet-level reference: sums per output index, epoch closes after 2^shift eops
  task automatic model_beat(input int c, input int d, input bit e);
    logic [59:0] ea;
    logic [4:0]  ec;
    for (int i = 0; i < 5; i++)
      if (map_id[i] == c) begin
        m_sum[i] += d;
        m_cnt[i]++;
      end
    if (e) begin
      m_pk++;
      if (m_pk == (1 << m_shift)) begin
        for (int i = 0; i < 5; i++) begin
          ea[i*12 +: 12] = 12'(m_sum[i] >> m_shift);
          ec[i] = (m_cnt[i] == (1 << m_shift));
          m_sum[i] = 0;
          m_cnt[i] = 0;
        end
        exp_avg_q.push_back(ea);
        exp_cpl_q.push_back(ec);
        m_pk = 0;
        m_shift = (avg_shift > 3'd4) ? 4 : int'(avg_shift);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int lat;
    int base;
    int n_pk;
    int gap;
    int nexp;
    logic [4:0] pres;
    int bch[$];
    int bd[$];
    logic [47:0] a_vals;

    reset = 1'b1; valid = 1'b0; chan = 5'd0; data = 12'd0; eop = 1'b0;
    avg_shift = 3'd0; hold = 1'b0;

    tbl[0] = '{5'h1F, {12'hFFF, 12'hABC, 12'h789, 12'h456, 12'h123},
               {12'hFFF, 12'hABC, 12'h789, 12'h456, 12'h123}, 5'h1F};
    tbl[1] = '{5'h1D, {12'h800, 12'h555, 12'h0AA, 12'h3C3, 12'h001},
               {12'h800, 12'h555, 12'h0AA, 12'h000, 12'h001}, 5'h1D};
    tbl[2] = '{5'h0A, {12'h000, 12'h111, 12'h000, 12'h222, 12'h000},
               {12'h000, 12'h111, 12'h000, 12'h222, 12'h000}, 5'h0A};
    tbl[3] = '{5'h00, 60'h0, 60'h0, 5'h00};

    repeat (3) @(negedge clk_core);
    #1;
    check("reset ch_avg", ch_avg, 60'h0);
    check("reset ch_complete", ch_complete, 5'h0);
    check("reset samples_ready", samples_ready, 1'b0);
    check("reset overrun", overrun, 1'b0);
    reset = 1'b0;

    // Single-packet epochs from the vector table
    set_shift(3'd0);
    for (int t = 0; t < 4; t++) begin
      start = pulse_cnt;
      send_pkt(tbl[t].present, tbl[t].d);
      wait_pub(start, $sformatf("tbl%0d publish", t), lat);
      if (lat > 0) begin
        check($sformatf("tbl%0d latency", t), lat, 3);
        check($sformatf("tbl%0d ch_avg", t), got_avg_q[start], tbl[t].exp_avg);
        check($sformatf("tbl%0d ch_complete", t), got_cpl_q[start], tbl[t].exp_cpl);
      end
      idle(4);
      check($sformatf("tbl%0d pulse count", t), pulse_cnt, start + 1);
    end

    // shift=2: four packets on channel 3 only
    set_shift(3'd2);
    start = pulse_cnt;
    a_vals = {12'h107, 12'h102, 12'h101, 12'h100};
    for (int p = 0; p < 4; p++) begin
      send_beat(5'd3, a_vals[p*12 +: 12], 1'b1);
      if (p < 3) begin
        idle(4);
        check($sformatf("shift2 no pulse after pkt%0d", p), pulse_cnt, start);
      end
    end
    wait_pub(start, "shift2 publish", lat);
    if (lat > 0) begin
      check("shift2 latency", lat, 3);
      check("shift2 ch_avg", got_avg_q[start], 60'h102);
      check("shift2 ch_complete", got_cpl_q[start], 5'h01);
    end
    idle(4);
    check("shift2 pulse count", pulse_cnt, start + 1);

    // shift request 7 clamps to 4: sixteen full-scale packets
    set_shift(3'd7);
    start = pulse_cnt;
    for (int p = 0; p < 16; p++) begin
      send_pkt(5'h1F, {5{12'hFFF}});
      if (p == 14) check("shift4 no early pulse", pulse_cnt, start);
    end
    wait_pub(start, "shift4 publish", lat);
    if (lat > 0) begin
      check("shift4 ch_avg", got_avg_q[start], {5{12'hFFF}});
      check("shift4 ch_complete", got_cpl_q[start], 5'h1F);
    end

    // Beat during FINISH seeds the next epoch
    set_shift(3'd0);
    start = pulse_cnt;
    send_beat(5'd3, 12'h011, 1'b1);
    send_beat(5'd3, 12'h022, 1'b0);
    send_beat(5'd6, 12'h033, 1'b1);
    wait_pub(start, "finish-beat first", lat);
    if (lat > 0) begin
      check("finish-beat ep1 ch_avg", got_avg_q[start], 60'h011);
      check("finish-beat ep1 ch_complete", got_cpl_q[start], 5'h01);
    end
    wait_pub(start + 1, "finish-beat second", lat);
    if (lat > 0) begin
      check("finish-beat ep2 ch_avg", got_avg_q[start+1], 60'h033022);
      check("finish-beat ep2 ch_complete", got_cpl_q[start+1], 5'h03);
    end

    // hold across two epochs: overrun, then newest result on release
    set_shift(3'd0);
    hold = 1'b1;
    start = pulse_cnt;
    send_pkt(5'h1F, {5{12'h010}});
    idle(4);
    send_pkt(5'h1F, {5{12'h020}});
    idle(4);
    check("hold no publish", pulse_cnt, start);
    check("hold overrun", overrun, 1'b1);
    @(negedge clk_core);
    hold = 1'b0;
    @(negedge clk_core);
    #1;
    check("release samples_ready", samples_ready, 1'b1);
    check("release ch_avg", ch_avg, {5{12'h020}});
    check("release ch_complete", ch_complete, 5'h1F);
    idle(3);
    check("release pulse count", pulse_cnt, start + 1);

    // Reset mid-epoch discards partial sums
    set_shift(3'd2);
    check("reset clears overrun", overrun, 1'b0);
    send_beat(5'd3, 12'h555, 1'b0);
    send_beat(5'd6, 12'h666, 1'b0);
    avg_shift = 3'd0;
    do_reset();
    check("midreset ch_avg", ch_avg, 60'h0);
    check("midreset ch_complete", ch_complete, 5'h0);
    start = pulse_cnt;
    send_pkt(5'h1F, {12'h00E, 12'h00D, 12'h00C, 12'h00B, 12'h00A});
    wait_pub(start, "post-reset publish", lat);
    if (lat > 0) begin
      check("post-reset latency", lat, 3);
      check("post-reset ch_avg", got_avg_q[start], {12'h00E, 12'h00D, 12'h00C, 12'h00B, 12'h00A});
      check("post-reset ch_complete", got_cpl_q[start], 5'h1F);
    end
    check("post-reset overrun", overrun, 1'b0);

    // Randomized packets scored against the reference model
    set_shift(3'($urandom_range(0, 3)));
    m_shift = int'(avg_shift);
    m_pk = 0;
    for (int i = 0; i < 5; i++) begin
      m_sum[i] = 0;
      m_cnt[i] = 0;
    end
    base = pulse_cnt;
    n_pk = 0;
    while (n_pk < 60 || m_pk != 0) begin
      gap = $urandom_range(0, 2);
      if (gap == 2 && $urandom_range(0, 2) == 0) begin
        idle(2);
        avg_shift = 3'($urandom_range(0, 7));
      end else if (gap > 0) begin
        idle(gap);
      end
      pres = 5'($urandom_range(0, 31));
      bch.delete();
      bd.delete();
      for (int i = 0; i < 5; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          bch.push_back(unm_id[$urandom_range(0, 4)]);
          bd.push_back($urandom_range(0, 4095));
        end
        if (pres[i]) begin
          bch.push_back(map_id[i]);
          bd.push_back($urandom_range(0, 4095));
        end
      end
      if (bch.size() == 0) begin
        bch.push_back(0);
        bd.push_back($urandom_range(0, 4095));
      end
      for (int b = 0; b < bch.size(); b++) begin
        model_beat(bch[b], bd[b], (b == bch.size() - 1));
        send_beat(5'(bch[b]), 12'(bd[b]), (b == bch.size() - 1));
      end
      n_pk++;
    end
    idle(6);
    nexp = exp_avg_q.size();
    check("random publish count", pulse_cnt - base, nexp);
    for (int k = 0; k < nexp; k++) begin
      if (base + k < got_avg_q.size()) begin
        check($sformatf("random ep%0d ch_avg", k), got_avg_q[base+k], exp_avg_q[k]);
        check($sformatf("random ep%0d ch_complete", k), got_cpl_q[base+k], exp_cpl_q[k]);
      end
    end
    check("random overrun", overrun, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
